// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU control path: ALU ops, opcodes,
// funct codes, FSM states and datapath select values.
package mc_pkg;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_NOR = 3'd6,
        ALU_DEC = 3'd7
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_e;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic state_e decode_next(input logic [5:0] op);
        state_e s;
        case (op)
            OP_RTYPE:                           s = S_EXEC_R;
            OP_LW, OP_SW:                       s = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                     s = S_BRANCH;
            OP_J:                               s = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:  s = S_EXEC_I;
            default:                            s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// mc_alu_dec: combinational ALU operation select from FSM state, opcode and funct.
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o
);

    alu_op_e op;

    always_comb begin
        op = ALU_NOP;
        case (state_i)
            S_FETCH, S_DECODE, S_MEM_ADDR: op = ALU_ADD;
            S_BRANCH:                      op = ALU_SUB;
            S_EXEC_R: begin
                case (funct_i)
                    FN_ADD:  op = ALU_ADD;
                    FN_SUB:  op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    default: op = ALU_NOP;
                endcase
            end
            S_EXEC_I: begin
                case (opcode_i)
                    OP_ADDI: op = ALU_ADD;
                    OP_ANDI: op = ALU_AND;
                    OP_ORI:  op = ALU_OR;
                    OP_XORI: op = ALU_XOR;
                    default: op = ALU_NOP;
                endcase
            end
            default: op = ALU_NOP;
        endcase
    end

    assign alu_op_o = op;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU. Optional build macro
// MC_CTRL_ILLEGAL_TRAP_EN turns ILLEGAL into a sticky terminal trap.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] pc_source,
    output logic       pc_write_en,
    output logic [3:0] state,
    output logic       illegal_op
);

    // state      | meaning
    // FETCH      | read instruction at PC, PC += 4 when memory completes
    // DECODE     | register read, branch target precompute
    // EXEC_R     | R-type ALU operation
    // R_WB       | write ALUOut to rd
    // EXEC_I     | immediate ALU operation
    // I_WB       | write ALUOut to rt
    // MEM_ADDR   | effective address for lw/sw
    // MEM_RD     | data read, waits for mem_ready
    // MEM_WB     | write MDR to rt
    // MEM_WR     | data write, waits for mem_ready
    // BRANCH     | compare, conditional PC update
    // JUMP       | PC <= jump target
    // ILLEGAL    | unknown opcode

    state_e     state_q, state_d;
    logic       mem_done;
    logic [2:0] alu_op_dec;

    assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_done) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(opcode);
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_done) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_done) state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign illegal_op = 1'b0;
`endif

    mc_alu_dec u_alu_dec (
        .state_i  (state_q),
        .opcode_i (opcode),
        .funct_i  (funct),
        .alu_op_o (alu_op_dec)
    );

    // Outputs are forced quiet while rst_n is low so that no strobe survives the reset edge.
    always_comb begin
        alu_op      = ALU_NOP;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_source   = PCSRC_ALU;
        pc_write_en = 1'b0;
        if (rst_n) begin
            alu_op = alu_op_dec;
            case (state_q)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = SRCB_FOUR;
                    ir_write    = mem_done;
                    pc_write_en = mem_done;
                end
                S_DECODE:   alu_src_b = SRCB_IMM_SH;
                S_EXEC_R:   alu_src_a = 1'b1;
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_I_WB:     reg_write = 1'b1;
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    pc_source   = PCSRC_ALUOUT;
                    pc_write_en = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_source   = PCSRC_JUMP;
                    pc_write_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
